// File: rtl/cim_pkg.sv
// Shared definitions for the CIM S-box responder: FSM state encoding, lane geometry
// and the forward AES S-box. The encryption bench reuses the S-box function.
package cim_pkg;

  localparam int CIM_LANES   = 16;
  localparam int CIM_DEMUX_W = 3;
  localparam int CIM_ROW_W   = 6;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FILL  = 2'd1,
    ST_PROG  = 2'd2,
    ST_READY = 2'd3
  } cim_state_t;

  localparam logic [7:0] SBOX_ROM [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  function automatic logic [7:0] aes_sbox(input logic [7:0] x);
    return SBOX_ROM[x];
  endfunction

endpackage

// File: rtl/cim_rd_pipe.sv
// One byte lane of the read path: address merge, out-of-range zeroing and an
// RD_LAT-deep data/valid pipeline that stalls while i_en is low.
module cim_rd_pipe #(
  parameter int RD_LAT  = 1,
  parameter int DEMUX_W = 3,
  parameter int ROW_W   = 6
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_en,
  input  logic               i_rd_acc,
  input  logic [DEMUX_W-1:0] i_demux,
  input  logic [ROW_W-1:0]   i_rwl,
  output logic [7:0]         o_addr,
  output logic               o_oor,
  input  logic [7:0]         i_tbl_data,
  output logic [7:0]         o_data,
  output logic               o_vld
);

  logic [7:0]        r_data [RD_LAT];
  logic [RD_LAT-1:0] r_vld;

  // The top bit of the demux field selects a bank that does not exist.
  assign o_addr = {i_demux[1:0], i_rwl};
  assign o_oor  = i_demux[DEMUX_W-1];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int k = 0; k < RD_LAT; k++) r_data[k] <= '0;
      r_vld <= '0;
    end else if (i_en) begin
      r_vld[0] <= i_rd_acc;
      if (i_rd_acc) r_data[0] <= o_oor ? 8'h00 : i_tbl_data;
      // Data only moves with its valid so the last stage holds between reads.
      for (int k = 1; k < RD_LAT; k++) begin
        r_vld[k] <= r_vld[k-1];
        if (r_vld[k-1]) r_data[k] <= r_data[k-1];
      end
    end
  end

  assign o_data = r_data[RD_LAT-1];
  assign o_vld  = r_vld[RD_LAT-1];

endmodule

// File: rtl/cim_sbox_responder.sv
// CIM S-box responder: 256x8 lookup table loaded by auto-fill or external programming,
// served to LANES byte lanes with a fixed read latency.
module cim_sbox_responder
  import cim_pkg::*;
#(
  parameter int LANES   = CIM_LANES,
  parameter int RD_LAT  = 1,
  parameter int DEMUX_W = CIM_DEMUX_W,
  parameter int ROW_W   = CIM_ROW_W
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_en,
  input  logic                     i_init_sbox,
  input  logic                     i_pgm_start,
  input  logic                     i_pgm_we,
  input  logic [7:0]               i_pgm_addr,
  input  logic [7:0]               i_pgm_data,
  input  logic                     i_pgm_done,
  input  logic                     i_rd_en,
  input  logic [LANES*DEMUX_W-1:0] i_demux_add,
  input  logic [LANES*ROW_W-1:0]   i_rwl_dec_add,
  input  logic                     i_err_clr,
  output logic [LANES*8-1:0]       o_rio,
  output logic                     o_rio_vld,
  output logic                     o_ready,
  output logic                     o_bsy,
  output logic [1:0]               o_err,
  output cim_state_t               o_state
);

  cim_state_t       r_state, w_state_nxt;
  logic [7:0]       r_cnt, w_cnt_nxt;
  logic             r_ready, r_bsy;
  logic [1:0]       r_err, w_err_nxt;
  logic             w_tbl_we;
  logic [7:0]       w_tbl_waddr, w_tbl_wdata;
  logic [7:0]       r_table [256];
  logic             w_rd_acc, w_rd_bad, w_oor_hit;
  logic [LANES-1:0] w_lane_oor, w_lane_vld;
  logic [7:0]       w_lane_addr [LANES];
  logic [7:0]       w_lane_tbl  [LANES];

  // Read handshake: no back-pressure. A read is taken on any i_en cycle with i_rd_en high
  // in READY; o_rio_vld pulses RD_LAT i_en cycles later. Reads outside READY only flag ERR[1].
  assign w_rd_acc  = i_rd_en & (r_state == ST_READY);
  assign w_rd_bad  = i_rd_en & (r_state != ST_READY);
  assign w_oor_hit = w_rd_acc & (|w_lane_oor);
  assign w_err_nxt = (r_err & ~{2{i_err_clr}}) | {w_rd_bad, w_oor_hit};

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_tbl_we    = 1'b0;
    w_tbl_waddr = r_cnt;
    w_tbl_wdata = aes_sbox(r_cnt);
    case (r_state)
      ST_EMPTY, ST_READY: begin
        if (i_init_sbox) begin
          w_state_nxt = ST_FILL;
          w_cnt_nxt   = 8'd0;
        end else if (i_pgm_start) begin
          w_state_nxt = ST_PROG;
        end
      end
      ST_FILL: begin
        w_tbl_we  = 1'b1;
        w_cnt_nxt = r_cnt + 8'd1;
        if (r_cnt == 8'hFF) w_state_nxt = ST_READY;
      end
      ST_PROG: begin
        if (i_pgm_we) begin
          w_tbl_we    = 1'b1;
          w_tbl_waddr = i_pgm_addr;
          w_tbl_wdata = i_pgm_data;
        end
        if (i_pgm_done) w_state_nxt = ST_READY;
      end
      default: w_state_nxt = ST_EMPTY;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_EMPTY;
      r_cnt   <= 8'd0;
      r_ready <= 1'b0;
      r_bsy   <= 1'b0;
      r_err   <= 2'b00;
    end else if (i_en) begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_ready <= (w_state_nxt == ST_READY);
      r_bsy   <= (w_state_nxt == ST_FILL) || (w_state_nxt == ST_PROG);
      r_err   <= w_err_nxt;
    end
  end

  // Table contents survive reset; only writes from FILL/PROG change them.
  always_ff @(posedge i_clk) begin
    if (!i_rst && i_en && w_tbl_we) r_table[w_tbl_waddr] <= w_tbl_wdata;
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    assign w_lane_tbl[g] = r_table[w_lane_addr[g]];

    cim_rd_pipe #(
      .RD_LAT (RD_LAT),
      .DEMUX_W(DEMUX_W),
      .ROW_W  (ROW_W)
    ) u_pipe (
      .i_clk     (i_clk),
      .i_rst     (i_rst),
      .i_en      (i_en),
      .i_rd_acc  (w_rd_acc),
      .i_demux   (i_demux_add[g*DEMUX_W +: DEMUX_W]),
      .i_rwl     (i_rwl_dec_add[g*ROW_W +: ROW_W]),
      .o_addr    (w_lane_addr[g]),
      .o_oor     (w_lane_oor[g]),
      .i_tbl_data(w_lane_tbl[g]),
      .o_data    (o_rio[g*8 +: 8]),
      .o_vld     (w_lane_vld[g])
    );
  end

  assign o_rio_vld = &w_lane_vld;
  assign o_ready   = r_ready;
  assign o_bsy     = r_bsy;
  assign o_err     = r_err;
  assign o_state   = r_state;

endmodule

// File: tb/tb_cim_sbox_responder.sv
// Directed bench for cim_sbox_responder: one instance at RD_LAT=1 and one at RD_LAT=3
// share all inputs so latency and stall behaviour are checked side by side.
module tb_cim_sbox_responder;
  import cim_pkg::*;

  logic         clk = 1'b0;
  logic         rst, en, init_sbox, pgm_start, pgm_we, pgm_done, rd_en, err_clr;
  logic [7:0]   pgm_addr, pgm_data;
  logic [47:0]  demux;
  logic [95:0]  rwl;

  logic [127:0] rio1, rio3;
  logic         vld1, vld3, rdy1, rdy3, bsy1, bsy3;
  logic [1:0]   err1, err3;
  cim_state_t   st1, st3;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  cim_sbox_responder #(.RD_LAT(1)) dut1 (
    .i_clk(clk), .i_rst(rst), .i_en(en), .i_init_sbox(init_sbox), .i_pgm_start(pgm_start),
    .i_pgm_we(pgm_we), .i_pgm_addr(pgm_addr), .i_pgm_data(pgm_data), .i_pgm_done(pgm_done),
    .i_rd_en(rd_en), .i_demux_add(demux), .i_rwl_dec_add(rwl), .i_err_clr(err_clr),
    .o_rio(rio1), .o_rio_vld(vld1), .o_ready(rdy1), .o_bsy(bsy1), .o_err(err1), .o_state(st1)
  );

  cim_sbox_responder #(.RD_LAT(3)) dut3 (
    .i_clk(clk), .i_rst(rst), .i_en(en), .i_init_sbox(init_sbox), .i_pgm_start(pgm_start),
    .i_pgm_we(pgm_we), .i_pgm_addr(pgm_addr), .i_pgm_data(pgm_data), .i_pgm_done(pgm_done),
    .i_rd_en(rd_en), .i_demux_add(demux), .i_rwl_dec_add(rwl), .i_err_clr(err_clr),
    .o_rio(rio3), .o_rio_vld(vld3), .o_ready(rdy3), .o_bsy(bsy3), .o_err(err3), .o_state(st3)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_all(input logic [7:0] a);
    for (int i = 0; i < 16; i++) begin
      demux[3*i +: 3] = {1'b0, a[7:6]};
      rwl[6*i +: 6]   = a[5:0];
    end
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (!rdy1 && n < 400) begin
      tick();
      n++;
    end
  endtask

  logic [127:0] exp_rio;
  logic [7:0]   s4_addr [8];
  logic         s4_rd   [8];
  logic         s4_en   [8];
  logic         s4_vld  [8];
  logic [7:0]   s4_byte [8];
  int           n_cyc;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; en = 1'b1; init_sbox = 1'b0; pgm_start = 1'b0; pgm_we = 1'b0; pgm_done = 1'b0;
    rd_en = 1'b0; err_clr = 1'b0; pgm_addr = 8'h00; pgm_data = 8'h00; demux = '0; rwl = '0;
    tick(); tick();
    rst = 1'b0;
    chk("rst_state1", 128'(st1), 128'(ST_EMPTY));
    chk("rst_state3", 128'(st3), 128'(ST_EMPTY));
    chk("rst_ready", 128'({rdy1, rdy3}), 128'(2'b00));
    chk("rst_bsy", 128'({bsy1, bsy3}), 128'(2'b00));
    chk("rst_vld", 128'({vld1, vld3}), 128'(2'b00));
    chk("rst_err", 128'({err1, err3}), 128'(4'b0000));
    chk("rst_rio1", rio1, 128'h0);
    chk("rst_rio3", rio3, 128'h0);

    // Read while EMPTY: ERR[1], no valid.
    rd_en = 1'b1; tick(); rd_en = 1'b0;
    chk("empty_rd_err1", 128'(err1), 128'(2'b10));
    chk("empty_rd_err3", 128'(err3), 128'(2'b10));
    chk("empty_rd_vld1", 128'(vld1), 128'(1'b0));
    tick(); tick();
    chk("empty_rd_vld3", 128'(vld3), 128'(1'b0));
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    chk("err_clr", 128'({err1, err3}), 128'(4'b0000));

    // Auto-fill: BSY for 256 cycles, then READY.
    init_sbox = 1'b1; tick(); init_sbox = 1'b0;
    chk("fill_state", 128'(st1), 128'(ST_FILL));
    chk("fill_bsy", 128'({bsy1, rdy1}), 128'(2'b10));
    wait_ready(n_cyc);
    chk("fill_cycles", 128'(n_cyc), 128'(256));
    chk("fill_done_flags", 128'({rdy1, bsy1, rdy3, bsy3}), 128'(4'b1010));

    set_all(8'h00);
    demux[5:3] = 3'b001;  rwl[11:6]  = 6'h13;
    demux[47:45] = 3'b011; rwl[95:90] = 6'h3F;
    exp_rio = {16{8'h63}};
    exp_rio[15:8]    = 8'hED;
    exp_rio[127:120] = 8'h16;
    rd_en = 1'b1; tick(); rd_en = 1'b0;
    chk("t1_vld1", 128'(vld1), 128'(1'b1));
    chk("t1_rio1", rio1, exp_rio);
    chk("t1_vld3_early", 128'(vld3), 128'(1'b0));
    tick();
    chk("t1_vld1_pulse", 128'(vld1), 128'(1'b0));
    chk("t1_rio1_hold", rio1, exp_rio);
    chk("t1_vld3_early2", 128'(vld3), 128'(1'b0));
    tick();
    chk("t1_vld3", 128'(vld3), 128'(1'b1));
    chk("t1_rio3", rio3, exp_rio);
    tick();

    // External programming with PGM_WE and PGM_DONE together.
    pgm_start = 1'b1; tick(); pgm_start = 1'b0;
    chk("prog_state", 128'(st1), 128'(ST_PROG));
    chk("prog_flags", 128'({rdy1, bsy1}), 128'(2'b01));
    pgm_we = 1'b1; pgm_done = 1'b1; pgm_addr = 8'h53; pgm_data = 8'hA5;
    tick();
    pgm_we = 1'b0; pgm_done = 1'b0;
    chk("prog_done_flags", 128'({rdy1, bsy1}), 128'(2'b10));
    set_all(8'h53);
    rd_en = 1'b1; tick(); rd_en = 1'b0;
    chk("t2_rio_pgm", rio1, {16{8'hA5}});
    set_all(8'h01);
    rd_en = 1'b1; tick(); rd_en = 1'b0;
    chk("t2_rio_stale", rio1, {16{8'h7C}});
    chk("t2_err", 128'(err1), 128'(2'b00));

    // Lane 4 out of range.
    set_all(8'h01);
    demux[14:12] = 3'b100;
    exp_rio = {16{8'h7C}};
    exp_rio[39:32] = 8'h00;
    rd_en = 1'b1; tick(); rd_en = 1'b0;
    chk("t3_oor_rio", rio1, exp_rio);
    chk("t3_oor_err", 128'(err1), 128'(2'b01));
    tick(); tick(); tick();

    // Four reads with a two-cycle EN stall in the middle, checked at RD_LAT=3.
    s4_addr = '{8'h00, 8'h53, 8'h00, 8'h00, 8'hFF, 8'h10, 8'h00, 8'h00};
    s4_rd   = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    s4_en   = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    s4_vld  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    s4_byte = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h63, 8'hA5, 8'h16, 8'hCA};
    for (int t = 0; t < 8; t++) begin
      set_all(s4_addr[t]);
      rd_en = s4_rd[t];
      en    = s4_en[t];
      tick();
      chk($sformatf("t4_vld_c%0d", t), 128'(vld3), 128'(s4_vld[t]));
      if (s4_vld[t]) chk($sformatf("t4_rio_c%0d", t), rio3, {16{s4_byte[t]}});
    end
    rd_en = 1'b0; en = 1'b1;
    tick();
    chk("t4_vld_after", 128'(vld3), 128'(1'b0));
    chk("t4_rio_hold", rio3, {16{8'hCA}});

    // Read accepted alongside INIT_SBOX returns pre-fill data; then reset mid-fill.
    set_all(8'h53);
    rd_en = 1'b1; init_sbox = 1'b1; tick(); rd_en = 1'b0; init_sbox = 1'b0;
    chk("t5_rd_vs_init_rio", rio1, {16{8'hA5}});
    chk("t5_fill_state", 128'(st1), 128'(ST_FILL));
    tick(); tick();
    chk("t5_inflight_vld3", 128'(vld3), 128'(1'b1));
    chk("t5_inflight_rio3", rio3, {16{8'hA5}});
    repeat (97) tick();
    rst = 1'b1; tick(); rst = 1'b0;
    chk("t5_rst_state", 128'({st1, st3}), 128'({ST_EMPTY, ST_EMPTY}));
    chk("t5_rst_flags", 128'({rdy1, bsy1, vld1, rdy3, bsy3, vld3}), 128'(6'b000000));
    chk("t5_rst_rio", rio1, 128'h0);
    init_sbox = 1'b1; pgm_start = 1'b1; tick(); init_sbox = 1'b0; pgm_start = 1'b0;
    chk("t5_init_wins", 128'(st1), 128'(ST_FILL));
    wait_ready(n_cyc);
    chk("t5_refill_cycles", 128'(n_cyc), 128'(256));
    set_all(8'h53);
    rd_en = 1'b1; tick(); rd_en = 1'b0;
    chk("t5_refill_rio", rio1, {16{8'hED}});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cim_sbox_responder.md
Name: cim_sbox_responder

Overview:
Responder side of the compute-in-memory S-box interface that the AES round datapath drives. It receives the per-lane DEMUX/RWL address pairs for 16 byte lanes and returns the looked-up bytes on RIO after a fixed read latency. The block holds a 256x8 lookup table, which is filled either by an internal auto-fill sequencer with the forward AES S-box or by an external programming port. It serves as the synthesizable stand-in for the CIM macro and as the bring-up responder for the encryption core.

Parameters:
LANES, 16, number of byte lanes served in parallel.
RD_LAT, 1, read latency in cycles from RD_EN to RIO_VLD; legal values are 1 to 3.
DEMUX_W, 3, width of each lane's demux address field.
ROW_W, 6, width of each lane's read-wordline address field.

Ports:
CLK  in  1  system clock.
RST  in  1  synchronous, active-high reset.
EN  in  1  global enable; when low, all state, counters and pipeline stages hold.
INIT_SBOX  in  1  pulse that starts the auto-fill of the table with the forward AES S-box.
PGM_START  in  1  pulse that enters external programming mode.
PGM_WE  in  1  table write strobe, honoured in PROG only.
PGM_ADDR  in  8  table write address.
PGM_DATA  in  8  table write data.
PGM_DONE  in  1  pulse that leaves PROG and enters READY.
RD_EN  in  1  read request, applied to all lanes in the same cycle.
DEMUX_ADD  in  LANES*DEMUX_W  flattened per-lane demux fields; lane i occupies bits [3i+2:3i].
RWL_DEC_ADD  in  LANES*ROW_W  flattened per-lane row fields; lane i occupies bits [6i+5:6i].
ERR_CLR  in  1  clears ERR.
RIO  out  LANES*8  looked-up bytes; lane i occupies bits [8i+7:8i].
RIO_VLD  out  1  RIO holds valid read data this cycle.
READY  out  1  table is loaded and reads are accepted.
BSY  out  1  high while in FILL or PROG.
ERR  out  2  sticky flags; bit0 = address out of range, bit1 = read while not READY.

Behaviour:
- Reset (synchronous, applies when EN is low as well): state=EMPTY, RIO=0, RIO_VLD=0, READY=0, BSY=0, ERR=0, fill counter=0, pipeline valid bits cleared. Table contents are not reset.
- State machine: EMPTY, FILL, PROG, READY.
  - EMPTY or READY, INIT_SBOX=1 -> FILL, counter=0.
  - EMPTY or READY, PGM_START=1 (and INIT_SBOX=0) -> PROG.
  - INIT_SBOX and PGM_START asserted together: INIT_SBOX wins.
  - FILL: each EN cycle writes table[cnt]=SBOX(cnt) and increments cnt. The cycle that writes cnt=255 transitions to READY. A full fill takes 256 EN cycles. INIT_SBOX and PGM_START are ignored during FILL.
  - PROG: PGM_WE=1 writes table[PGM_ADDR]=PGM_DATA. PGM_DONE=1 -> READY. If PGM_WE and PGM_DONE are asserted together, the write is performed and READY is entered next cycle. INIT_SBOX is ignored in PROG.
- READY and BSY are registered, decoded from the state.
- Read:
  - A read is accepted when RD_EN=1, EN=1 and state=READY.
  - Each lane forms its 8-bit address as {DEMUX_ADD_i[1:0], RWL_DEC_ADD_i}.
  - If DEMUX_ADD_i[2]=1, that lane's data byte is forced to 0x00 and ERR[0] is set; all other lanes are unaffected.
  - Data and valid travel through RD_LAT register stages. RIO_VLD pulses exactly RD_LAT EN cycles after the accepting cycle. Back-to-back reads are supported at full throughput.
  - RIO holds its last value when RIO_VLD=0.
- Read while not READY: RD_EN=1 in EMPTY, FILL or PROG sets ERR[1]. No valid is generated, and the pipeline inputs are not loaded.
- Reads are not blocked by a pending INIT_SBOX/PGM_START. A read accepted in READY in the same cycle as INIT_SBOX still completes with the pre-fill data. Reads in flight when the state leaves READY also complete.
- ERR: sticky. ERR_CLR clears it. If a set condition and ERR_CLR occur in the same cycle, set wins.
- EN=0 freezes the state, the counter, the pipeline stages and RIO_VLD. Writes and state changes are suppressed.
- Reset mid-FILL or mid-PROG: state returns to EMPTY, and a new INIT_SBOX or PGM sequence is required.

Decomposition:
- Shared package cim_pkg holds:
  - the state enum;
  - the LANES, DEMUX_W and ROW_W constants;
  - the 256-entry forward AES S-box constant function, also reused by the encryption bench scoreboard.
- One sub-module, cim_rd_pipe, is instantiated once per lane. It contains the address merge, the out-of-range zeroing and the RD_LAT-stage data/valid pipeline with EN stall. The table and the state machine stay in the top module.

Test Plan:
1. Reset, then INIT_SBOX pulse with EN=1 -> BSY=1 for 256 cycles, then READY=1. Read with lane0={3'b000,6'h00}, lane1={3'b001,6'h13}, lane15={3'b011,6'h3F} -> RIO lane0=0x63, lane1=0xED, lane15=0x16, with RIO_VLD exactly RD_LAT cycles later.
2. PGM_START, then PGM_WE addr=0x53 data=0xA5 together with PGM_DONE -> READY next cycle. A read of 0x53 on all lanes returns 0xA5 on all 16 lanes. A read of 0x01 returns the stale table value.
3. RD_EN in EMPTY -> RIO_VLD stays 0 and ERR=2'b10. ERR_CLR -> ERR=0. Lane 4 demux=3'b100 in READY -> lane4 byte=0x00, other lanes correct, ERR[0]=1.
4. RD_LAT=3: reads on 4 consecutive cycles, EN dropped for 2 cycles mid-stream -> four RIO_VLD pulses, in order, each delayed by exactly 2 extra cycles, data unchanged.
5. RST at fill cycle 100 -> next cycle state=EMPTY, READY=0, BSY=0, RIO_VLD=0. A new INIT_SBOX completes after 256 cycles. INIT_SBOX and PGM_START on the same cycle -> FILL.
